operand_latch: RTL and testbench

Decode/execute pipeline register that captures the two register-file read values produced by the read-select muxes and hands them to the execute stage. A combinational write-back bypass corrects values that are stale because the register file commits writes on the clock edge. While stalled, the block also re-applies write-backs to the operands it is holding. It carries the instruction word and the source selects alongside the operands, supports stall and flush, and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/operand_latch.sv | 97 +++++++++
 tb/tb_operand_latch.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/operand_latch.sv
// rtl/operand_latch.sv - decode/execute operand pipeline register with write-back bypass
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   stall, flush          hold contents / insert a bubble (flush wins)
//   in_valid, instr_in    instruction presented by decode
//   rs1_sel, rs2_sel      source register selects
//   rs1_data, rs2_data    read-mux outputs for those selects
//   wb_en, wb_sel, wb_data  write-back committing this cycle
//   out_valid, instr_out  latched instruction for execute
//   op_a, op_b            latched operands
//   rs1_out, rs2_out      latched source selects for hazard logic
//   stall_count           saturating count of stalled cycles holding a valid instruction
module operand_latch (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] instr_in,
  input  logic [4:0]  rs1_sel,
  input  logic [4:0]  rs2_sel,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_en,
  input  logic [4:0]  wb_sel,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] instr_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [31:0] stall_count
);

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic        hold_hit_a;
  logic        hold_hit_b;

  // The register file commits on the same edge we sample, so its read
  // value is stale when write-back targets the register being read.
  always_comb begin
    fwd_a = rs1_data;
    fwd_b = rs2_data;
    if (rs1_sel == 5'd0)
      fwd_a = 32'd0;
    else if (wb_en && (wb_sel == rs1_sel))
      fwd_a = wb_data;
    if (rs2_sel == 5'd0)
      fwd_b = 32'd0;
    else if (wb_en && (wb_sel == rs2_sel))
      fwd_b = wb_data;
  end

  // While held, a retiring write-back to a held source must still reach
  // the operand; register 0 is never updated.
  always_comb begin
    hold_hit_a = wb_en && (wb_sel != 5'd0) && (wb_sel == rs1_out);
    hold_hit_b = wb_en && (wb_sel != 5'd0) && (wb_sel == rs2_out);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      op_a        <= 32'd0;
      op_b        <= 32'd0;
      instr_out   <= 32'd0;
      rs1_out     <= 5'd0;
      rs2_out     <= 5'd0;
      stall_count <= 32'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      instr_out <= 32'd0;
      rs1_out   <= 5'd0;
      rs2_out   <= 5'd0;
    end else if (stall) begin
      if (hold_hit_a)
        op_a <= wb_data;
      if (hold_hit_b)
        op_b <= wb_data;
      if (out_valid && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end else begin
      out_valid <= in_valid;
      op_a      <= fwd_a;
      op_b      <= fwd_b;
      instr_out <= instr_in;
      rs1_out   <= rs1_sel;
      rs2_out   <= rs2_sel;
    end
  end

endmodule

// File: tb/tb_operand_latch.sv
// tb/tb_operand_latch.sv - directed vector bench for operand_latch
module tb_operand_latch;

  logic        clock = 1'b0;
  logic        reset, stall, flush, in_valid, wb_en;
  logic [31:0] instr_in, rs1_data, rs2_data, wb_data;
  logic [4:0]  rs1_sel, rs2_sel, wb_sel;
  logic        out_valid;
  logic [31:0] op_a, op_b, instr_out, stall_count;
  logic [4:0]  rs1_out, rs2_out;

  int n_vec = 0;
  int n_miss = 0;

  operand_latch dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .instr_in(instr_in),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .out_valid(out_valid), .op_a(op_a), .op_b(op_b),
    .instr_out(instr_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        we;
    logic [4:0]  ws;
    logic [31:0] wd;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic v, input logic [31:0] instr, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic we, input logic [4:0] ws, input logic [31:0] wd);
    in_valid = v; instr_in = instr; rs1_sel = s1; rs2_sel = s2;
    rs1_data = d1; rs2_data = d2; wb_en = we; wb_sel = ws; wb_data = wd;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'hA000_0001, 5'd5,  5'd6, 32'd10, 32'd4,  1'b1, 5'd5,  32'd99,         32'd99,         32'd4};
    vecs[1] = '{1'b1, 32'hA000_0002, 5'd0,  5'd0, 32'd55, 32'd55, 1'b1, 5'd0,  32'd99,         32'd0,          32'd0};
    vecs[2] = '{1'b1, 32'hA000_0003, 5'd3,  5'd3, 32'd11, 32'd12, 1'b1, 5'd0,  32'd99,         32'd11,         32'd12};
    vecs[3] = '{1'b1, 32'hA000_0004, 5'd7,  5'd7, 32'd1,  32'd2,  1'b0, 5'd7,  32'd99,         32'd1,          32'd2};
    vecs[4] = '{1'b0, 32'hA000_0005, 5'd2,  5'd9, 32'd20, 32'd21, 1'b1, 5'd9,  32'd5,          32'd20,         32'd5};
    vecs[5] = '{1'b1, 32'hA000_0006, 5'd31, 5'd1, 32'd30, 32'd31, 1'b1, 5'd31, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd31};
    vecs[6] = '{1'b1, 32'hA000_0007, 5'd4,  5'd4, 32'd8,  32'd9,  1'b1, 5'd4,  32'd123,        32'd123,        32'd123};

    // Reset with random inputs, two cycles
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load($urandom_range(0, 1), $urandom, 5'($urandom), 5'($urandom),
           $urandom, $urandom, $urandom_range(0, 1), 5'($urandom), $urandom);
      stall = $urandom_range(0, 1);
      tick();
    end
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_rs1", {27'd0, rs1_out}, 32'd0);
    chk("rst_rs2", {27'd0, rs2_out}, 32'd0);
    chk("rst_count", stall_count, 32'd0);

    // First load after release
    reset = 1'b0; stall = 1'b0;
    load(1'b1, 32'h1234_5678, 5'd3, 5'd0, 32'd7, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_instr", instr_out, 32'h1234_5678);
    chk("first_op_a", op_a, 32'd7);

    // Table: one load per cycle, back-to-back, bubble in the middle
    for (int i = 0; i < 7; i++) begin
      load(vecs[i].v, vecs[i].instr, vecs[i].s1, vecs[i].s2, vecs[i].d1, vecs[i].d2,
           vecs[i].we, vecs[i].ws, vecs[i].wd);
      tick();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].v});
      chk($sformatf("v%0d_instr", i), instr_out, vecs[i].instr);
      chk($sformatf("v%0d_op_a", i), op_a, vecs[i].exp_a);
      chk($sformatf("v%0d_op_b", i), op_b, vecs[i].exp_b);
      chk($sformatf("v%0d_rs1", i), {27'd0, rs1_out}, {27'd0, vecs[i].s1});
      chk($sformatf("v%0d_rs2", i), {27'd0, rs2_out}, {27'd0, vecs[i].s2});
    end

    // Stall refresh
    load(1'b1, 32'hBEEF_0008, 5'd8, 5'd9, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0);
    tick();
    chk("sr_load_a", op_a, 32'd1);
    stall = 1'b1;
    load(1'b1, 32'hDEAD_DEAD, 5'd1, 5'd1, 32'd500, 32'd500, 1'b0, 5'd8, 32'd42);
    tick();
    chk("sr1_op_a", op_a, 32'd1);
    chk("sr1_count", stall_count, 32'd1);
    wb_en = 1'b1;
    tick();
    chk("sr2_op_a", op_a, 32'd42);
    chk("sr2_op_b", op_b, 32'd2);
    chk("sr2_count", stall_count, 32'd2);
    wb_sel = 5'd9; wb_data = 32'd77;
    tick();
    chk("sr3_op_a", op_a, 32'd42);
    chk("sr3_op_b", op_b, 32'd77);
    chk("sr3_instr", instr_out, 32'hBEEF_0008);
    chk("sr3_rs1", {27'd0, rs1_out}, 32'd8);
    chk("sr3_count", stall_count, 32'd3);

    // Flush beats stall; count frozen
    wb_en = 1'b0; flush = 1'b1;
    tick();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_instr", instr_out, 32'd0);
    chk("fl_op_a", op_a, 32'd0);
    chk("fl_count", stall_count, 32'd3);
    flush = 1'b0;
    tick();
    tick();
    chk("idle_stall_count", stall_count, 32'd3);

    // Saturation via backdoor deposit
    stall = 1'b0;
    load(1'b1, 32'hCAFE_0001, 5'd2, 5'd3, 32'd5, 32'd6, 1'b0, 5'd0, 32'd0);
    tick();
    force dut.stall_count = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat%0d_count", i), stall_count, 32'hFFFF_FFFF);
    end

    // Reset while stalled clears held instruction and counter
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_count", stall_count, 32'd0);
    chk("mid_rst_instr", instr_out, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
